// File: rtl/y_signature_collector.sv
// y_signature_collector
// Folds the 82-bit result bus y into a 32-bit MISR signature over a
// programmed number of samples. An optional warm-up precedes the capture.
// The final signature is compared against exp_sig and can be shifted out
// serially, MSB first.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; the signature holds SEED
// SKIP    | warm-up cycles after start; y is ignored
// CAPTURE | y is folded into the MISR once per clock
// DONE    | signature holds; match is valid; shift_en shifts sig out
module y_signature_collector #(
  parameter int                DATA_W = 82,
  parameter int                SIG_W  = 32,
  parameter logic [SIG_W-1:0]  POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED   = 32'h00000000,
  parameter int                CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  skip_cycles,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [DATA_W-1:0] y,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [SIG_W-1:0]  sig,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              sig_sout
);

  // Number of SIG_W-wide chunks needed to cover y; the last chunk is zero-padded.
  localparam int NCH = (DATA_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     skip_cnt;
  logic [CNT_W-1:0]     num_lat;
  logic [NCH*SIG_W-1:0] ypad;
  logic [SIG_W-1:0]     fold;
  logic [SIG_W-1:0]     misr_next;
  logic                 load;
  logic                 cap;
  logic                 shift;

  // XOR-fold y into one SIG_W word, then form the next MISR value.
  always_comb begin
    ypad = '0;
    ypad[DATA_W-1:0] = y;
    fold = '0;
    for (int i = 0; i < NCH; i++) begin
      fold = fold ^ ypad[i*SIG_W +: SIG_W];
    end
    misr_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes; start wins over shift_en in DONE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    cap        = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (skip_cycles != '0)      state_next = SKIP;
          else if (num_samples != '0) state_next = CAPTURE;
          else                        state_next = DONE;
        end
      end
      SKIP: begin
        // Treating 0 like 1 keeps a corrupted counter from stalling the run.
        if (skip_cnt <= CNT_W'(1)) begin
          state_next = (num_lat != '0) ? CAPTURE : DONE;
        end
      end
      CAPTURE: begin
        cap = 1'b1;
        if ((sample_cnt + CNT_W'(1)) == num_lat) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load = 1'b1;
          if (skip_cycles != '0)      state_next = SKIP;
          else if (num_samples != '0) state_next = CAPTURE;
          else                        state_next = IDLE;
          if (skip_cycles == '0 && num_samples == '0) state_next = DONE;
        end else if (shift_en) begin
          shift = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Signature, counters and latched run parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig        <= SEED;
      sample_cnt <= '0;
      skip_cnt   <= '0;
      num_lat    <= '0;
    end else if (load) begin
      sig        <= SEED;
      sample_cnt <= '0;
      skip_cnt   <= skip_cycles;
      num_lat    <= num_samples;
    end else begin
      if (cap) begin
        sig <= misr_next;
        if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
      end else if (shift) begin
        sig <= {sig[SIG_W-2:0], 1'b0};
      end
      if (state == SKIP && skip_cnt != '0) skip_cnt <= skip_cnt - CNT_W'(1);
    end
  end

  assign busy     = (state == SKIP) || (state == CAPTURE);
  assign done     = (state == DONE);
  assign match    = done && (sig == exp_sig);
  assign sig_sout = sig[SIG_W-1];

endmodule
